// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED pattern controller.
//   Mode encoding (2 bits) and press FSM state encoding (2 bits),
//   plus the mode-advance helper used on a short press.
package led_ctrl_pkg;

    localparam int unsigned MODE_W  = 2;
    localparam int unsigned PRESS_W = 2;

    localparam logic [MODE_W-1:0] MODE_OFF     = 2'd0;
    localparam logic [MODE_W-1:0] MODE_SOLID   = 2'd1;
    localparam logic [MODE_W-1:0] MODE_BLINK   = 2'd2;
    localparam logic [MODE_W-1:0] MODE_BREATHE = 2'd3;

    localparam logic [PRESS_W-1:0] PRESS_IDLE      = 2'd0;
    localparam logic [PRESS_W-1:0] PRESS_HELD      = 2'd1;
    localparam logic [PRESS_W-1:0] PRESS_RESET_REQ = 2'd2;

    // Short press steps through the modes; 3 wraps back to 0.
    function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m);
        return m + MODE_W'(1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser and tick-based debouncer.
//   clk48   : system clock
//   rst     : asynchronous active-high reset
//   tick    : one-cycle sampling strobe
//   btn_raw : raw button level (active-low)
//   stable  : debounced level, resets to 1 (released)
//   fall    : one-cycle pulse when stable goes 1->0
//   rise    : one-cycle pulse when stable goes 0->1
module btn_debounce
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 10
) (
    input  logic clk48,
    input  logic rst,
    input  logic tick,
    input  logic btn_raw,
    output logic stable,
    output logic fall,
    output logic rise
);

    localparam int unsigned DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

    logic          sync1;
    logic          sync2;
    logic [DW-1:0] dcnt;

    // Two-flop synchroniser; idle level is released (1).
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // A new level must differ from stable on DEBOUNCE_TICKS consecutive ticks.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            dcnt   <= '0;
            stable <= 1'b1;
            fall   <= 1'b0;
            rise   <= 1'b0;
        end else begin
            fall <= 1'b0;
            rise <= 1'b0;
            if (tick) begin
                if (sync2 == stable) begin
                    dcnt <= '0;
                end else if (dcnt == DW'(DEBOUNCE_TICKS - 1)) begin
                    stable <= sync2;
                    dcnt   <= '0;
                    fall   <= ~sync2;
                    rise   <= sync2;
                end else begin
                    dcnt <= dcnt + DW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// RGB LED pattern controller with button mode select and long-press reset.
//   clk48   : system clock
//   rst     : asynchronous active-high reset
//   usr_btn : raw user button, active-low
//   color   : per-channel duty, channel i at [i*PWM_BITS +: PWM_BITS]
//   led_n   : active-low LED drive, registered
//   rst_n   : active-low bootloader reset request, registered
//   mode    : current pattern mode, registered
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 48000000,
    parameter int unsigned CHANNELS       = 3,
    parameter int unsigned PWM_BITS       = 8,
    parameter int unsigned TICK_DIV       = CLK_HZ / 1000,
    parameter int unsigned DEBOUNCE_TICKS = 10,
    parameter int unsigned LONG_TICKS     = 2000,
    parameter int unsigned BLINK_TICKS    = 250
) (
    input  logic                         clk48,
    input  logic                         rst,
    input  logic                         usr_btn,
    input  logic [CHANNELS*PWM_BITS-1:0] color,
    output logic [CHANNELS-1:0]          led_n,
    output logic                         rst_n,
    output logic [1:0]                   mode
);

    localparam int unsigned TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HW   = $clog2(LONG_TICKS + 1);
    localparam int unsigned BW   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int unsigned PW2  = 2 * PWM_BITS;
    localparam logic [PWM_BITS-1:0] ENV_MAX = '1;

    logic [TW-1:0]       tcnt;
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [BW-1:0]       bcnt;
    logic                phase;
    logic [PWM_BITS-1:0] env;
    logic                env_down;

    logic                btn_stable;
    logic                btn_fall;
    logic                btn_rise;

    logic [PRESS_W-1:0]  state_q;
    logic [PRESS_W-1:0]  state_d;
    logic [HW-1:0]       hold_q;
    logic [HW-1:0]       hold_d;
    logic [1:0]          mode_d;

    logic [CHANNELS-1:0] on_c;

    // Tick divider; tick is high on the cycle the counter sits at 0 after wrapping.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (tcnt == TW'(TICK_DIV - 1));
            tcnt <= (tcnt == TW'(TICK_DIV - 1)) ? '0 : tcnt + TW'(1);
        end
    end

    // Free-running PWM ramp.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Blink phase toggles every BLINK_TICKS ticks, independent of mode.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            if (bcnt == BW'(BLINK_TICKS - 1)) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt <= bcnt + BW'(1);
            end
        end
    end

    // Triangle envelope; turns around without repeating the end values.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            env      <= '0;
            env_down <= 1'b0;
        end else if (tick) begin
            if (!env_down) begin
                if (env == ENV_MAX) begin
                    env      <= ENV_MAX - PWM_BITS'(1);
                    env_down <= 1'b1;
                end else begin
                    env <= env + PWM_BITS'(1);
                end
            end else begin
                if (env == '0) begin
                    env      <= PWM_BITS'(1);
                    env_down <= 1'b0;
                end else begin
                    env <= env - PWM_BITS'(1);
                end
            end
        end
    end

    btn_debounce #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_btn (
        .clk48   (clk48),
        .rst     (rst),
        .tick    (tick),
        .btn_raw (usr_btn),
        .stable  (btn_stable),
        .fall    (btn_fall),
        .rise    (btn_rise)
    );

    // Press FSM state, hold counter, mode and reset request registers.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            state_q <= PRESS_IDLE;
            hold_q  <= '0;
            mode    <= MODE_OFF;
            rst_n   <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            mode    <= mode_d;
            rst_n   <= (state_d != PRESS_RESET_REQ);
        end
    end

    // Press FSM next state; the long-press check outranks a release on the same cycle.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        mode_d  = mode;
        case (state_q)
            PRESS_IDLE: begin
                if (btn_fall) begin
                    state_d = PRESS_HELD;
                    hold_d  = '0;
                end
            end
            PRESS_HELD: begin
                if (hold_q == HW'(LONG_TICKS)) begin
                    state_d = PRESS_RESET_REQ;
                end else if (btn_rise) begin
                    state_d = PRESS_IDLE;
                    mode_d  = next_mode(mode);
                end else if (tick) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            PRESS_RESET_REQ: begin
                state_d = PRESS_RESET_REQ;
            end
            default: begin
                state_d = PRESS_IDLE;
            end
        endcase
    end

    // Per-channel duty select and PWM compare.
    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
        logic [PWM_BITS-1:0] col;
        logic [PW2-1:0]      prod;
        logic [PWM_BITS-1:0] duty_c;

        assign col  = color[i*PWM_BITS +: PWM_BITS];
        assign prod = PW2'(col) * PW2'(env);

        always_comb begin
            duty_c = '0;
            case (mode)
                MODE_SOLID:   duty_c = col;
                MODE_BLINK:   duty_c = phase ? col : '0;
                MODE_BREATHE: duty_c = PWM_BITS'(prod >> PWM_BITS);
                default:      duty_c = '0;
            endcase
        end

        assign on_c[i] = (pwm_cnt < duty_c);
    end

    // Registered active-low LED drive.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            led_n <= '1;
        end else begin
            led_n <= ~on_c;
        end
    end

endmodule
